mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Memory stage of the RV32I pipeline, directly downstream of Execute. Consumes the ALU result
//  (address or value), store data, funct3 and the writeback destination. Issues byte-enabled
//  word accesses to data memory over a req/ack handshake and sign/zero-extends loads.
//  Passes non-memory ALU results to writeback and reports misaligned, illegal and timeout faults.
// PARAMETERS
//  TIMEOUT   255  max cycles dmem_req stays high without dmem_ack before fault; 0 = never time out
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   synchronous active-high reset
//  in_valid     in   1   Execute presents an instruction this cycle
//  in_ready     out  1   stage can accept (high only in IDLE)
//  mem_read     in   1   load instruction
//  mem_write    in   1   store instruction
//  reg_write    in   1   instruction writes rd
//  funct3       in   3   access size/sign (RV32I load/store encoding)
//  alu_result   in   32  effective address (load/store) or result (pass-through)
//  store_data   in   32  rs2 value for stores
//  rd           in   5   destination register
//  dmem_req     out  1   memory request, held until ack or timeout
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  word address {alu_result[31:2],2'b00}
//  dmem_be      out  4   byte enables
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_ack     in   1   memory completes request this cycle; rdata valid for reads
//  dmem_rdata   in   32  read word
//  out_valid    out  1   one-cycle pulse: result for writeback
//  out_we       out  1   = reg_write & (rd!=0) & (out_fault==0)
//  out_rd       out  5   destination register
//  out_data     out  32  load data / pass-through value; 0 for stores and faults
//  out_fault    out  2   00 none, 01 misaligned, 10 illegal funct3, 11 timeout
// BEHAVIOUR
//  - Reset: state=IDLE. in_ready=1, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0,
//    out_valid=0, out_we=0, out_rd=0, out_data=0, out_fault=00, timeout counter=0.
//  - Reset during BUSY drops dmem_req at that edge with no result. A later dmem_ack is ignored.
//  - FSM IDLE -> BUSY -> IDLE. Accept = in_valid & in_ready.
//  - Accept with mem_read=mem_write=0: pass-through. Next cycle out_valid=1, out_data=alu_result.
//    One instruction per cycle.
//  - Accept with both mem_read and mem_write set: treated as illegal (fault 10).
//  - Legal funct3 values: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
//    Any other value gives fault 10.
//  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0 (fault 01).
//  - Faults are checked at accept. On a fault: no dmem_req, next cycle out_valid=1 with the fault
//    code, out_data=0, and the FSM stays in IDLE.
//  - Legal load/store: registered dmem_req=1 on the cycle after accept, and state=BUSY (in_ready=0).
//    dmem_addr, dmem_we, dmem_be and dmem_wdata are held constant while req is high.
//  - Byte enables and write data:
//    SB: be=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}
//    SH: be=addr[1]?4'b1100:4'b0011, wdata={2{sd[15:0]}}
//    SW: be=4'b1111, wdata=sd
//    Loads use the same be pattern.
//  - Ack handling: dmem_ack counts only when sampled high with dmem_req high. This includes the
//    first req cycle (zero wait). On ack: dmem_req=0 and state=IDLE at that edge. out_valid=1 on
//    the next cycle, so latency from req rise to result is waits+1.
//  - Load data: lane = dmem_rdata >> (8*addr[1:0]). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
//  - Store result: out_data=0.
//  - Timeout: counter increments every BUSY cycle without ack. If it reaches TIMEOUT and ack is
//    still low: drop req, state=IDLE, next cycle out_valid=1 with fault 11.
//    An ack on the TIMEOUT-th cycle wins over the timeout.
//  - New accept is possible in the same cycle out_valid pulses for the previous op; in_ready is
//    high in IDLE regardless of out_valid.
// TESTING
//  1 reset, then pass-through alu_result=32'h1234, rd=5, reg_write=1 on 3 consecutive cycles
//    -> out_valid on 3 consecutive cycles, 1-cycle latency, out_we=1
//  2 LB addr=0x1003, rdata=0x80FF_FF7F, ack after 2 waits -> dmem_addr=0x1000, be=1000,
//    out_data=0xFFFF_FF80; LBU -> 0x0000_0080
//  3 SH addr=0x2002, store_data=0xAAAA_BEEF, zero-wait ack -> be=1100, wdata=0xBEEF_BEEF,
//    we=1, out_we=0, in_ready low for exactly one cycle
//  4 LW addr=0x3001 -> no dmem_req, out_fault=01, out_we=0; funct3=011 load -> out_fault=10
//  5 TIMEOUT=4, LW never acked -> req high exactly 4 cycles, then out_fault=11.
//    Repeat with ack on 4th cycle -> normal load data, no fault
//  6 assert rst while BUSY with req high -> req=0 next cycle, no out_valid.
//    Later stray ack ignored; next pass-through op completes normally

Source files
------------

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: issues byte-enabled word accesses over a req/ack handshake,
// extends load data, passes ALU results through and reports access faults.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        reg_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        out_valid,
   output logic        out_we,
   output logic [4:0]  out_rd,
   output logic [31:0] out_data,
   output logic [1:0]  out_fault
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] F_NONE  = 2'b00;
   localparam logic [1:0] F_ALIGN = 2'b01;
   localparam logic [1:0] F_ILLEG = 2'b10;
   localparam logic [1:0] F_TMO   = 2'b11;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_f3;
   logic [1:0]       op_off;
   logic             op_load;
   logic             op_rw;
   logic [4:0]       op_rd;

   logic             accept_c;
   logic             illegal_c;
   logic             misaligned_c;
   logic [3:0]       be_c;
   logic [31:0]      wdata_c;
   logic [31:0]      lane_c;
   logic [31:0]      load_data_c;

   assign accept_c = in_valid & in_ready;

   // Decode of the incoming instruction: legality, alignment, lanes.
   always_comb begin
      illegal_c    = 1'b0;
      misaligned_c = 1'b0;
      be_c         = 4'b1111;
      wdata_c      = store_data;
      if (mem_read && mem_write)
         illegal_c = 1'b1;
      else if (mem_write)
         illegal_c = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
      else if (mem_read)
         illegal_c = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                       funct3 == 3'b100 || funct3 == 3'b101);
      case (funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << alu_result[1:0];
            wdata_c = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_c         = alu_result[1] ? 4'b1100 : 4'b0011;
            wdata_c      = {2{store_data[15:0]}};
            misaligned_c = alu_result[0];
         end
         default: misaligned_c = (alu_result[1:0] != 2'b00);
      endcase
   end

   // Lane select and sign/zero extension of the returned word.
   always_comb begin
      lane_c = dmem_rdata >> {op_off, 3'b000};
      case (op_f3)
         3'b000:  load_data_c = {{24{lane_c[7]}}, lane_c[7:0]};
         3'b001:  load_data_c = {{16{lane_c[15]}}, lane_c[15:0]};
         3'b100:  load_data_c = {24'd0, lane_c[7:0]};
         3'b101:  load_data_c = {16'd0, lane_c[15:0]};
         default: load_data_c = lane_c;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         out_valid  <= 1'b0;
         out_we     <= 1'b0;
         out_rd     <= '0;
         out_data   <= '0;
         out_fault  <= F_NONE;
         cnt        <= '0;
         op_f3      <= '0;
         op_off     <= '0;
         op_load    <= 1'b0;
         op_rw      <= 1'b0;
         op_rd      <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  out_rd <= rd;
                  if (!mem_read && !mem_write) begin
                     out_valid <= 1'b1;
                     out_we    <= reg_write && (rd != 5'd0);
                     out_data  <= alu_result;
                     out_fault <= F_NONE;
                  end else if (illegal_c || misaligned_c) begin
                     out_valid <= 1'b1;
                     out_we    <= 1'b0;
                     out_data  <= '0;
                     out_fault <= illegal_c ? F_ILLEG : F_ALIGN;
                  end else begin
                     state      <= BUSY;
                     in_ready   <= 1'b0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= mem_write;
                     dmem_addr  <= {alu_result[31:2], 2'b00};
                     dmem_be    <= be_c;
                     dmem_wdata <= wdata_c;
                     cnt        <= '0;
                     op_f3      <= funct3;
                     op_off     <= alu_result[1:0];
                     op_load    <= mem_read;
                     op_rw      <= reg_write;
                     op_rd      <= rd;
                  end
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  dmem_req  <= 1'b0;
                  out_valid <= 1'b1;
                  out_we    <= op_rw && (op_rd != 5'd0);
                  out_data  <= op_load ? load_data_c : 32'd0;
                  out_fault <= F_NONE;
               end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                  // Ack on this same cycle would have taken the branch above.
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  dmem_req  <= 1'b0;
                  out_valid <= 1'b1;
                  out_we    <= 1'b0;
                  out_data  <= '0;
                  out_fault <= F_TMO;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
